// File: rtl/vliw_fwd_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// vliw_fwd_hazard_unit_if
// Bundles the ID-stage request, pipeline result buses and forwarding outputs
// of the VLIW forwarding/hazard unit.
//
// Handshake: there is no ready signal. A bundle is accepted into EX on a
// rising edge when id_valid = 1, stall = 0 and flush = 0. When stall = 1 the
// driver must hold the same bundle on the id_* signals for the next cycle.
//
// Modports:
//   master - pipeline side: drives id_*, flush and data buses, reads results
//   slave  - hazard unit: reads id_*, flush and data buses, drives
//            opnd, fwd_sel, stall and stall_count
// ----------------------------------------------------------------------------
interface vliw_fwd_hazard_unit_if #(
    parameter int SLOTS = 2,
    parameter int AW    = 3,
    parameter int DW    = 32,
    parameter int CW    = 16
);
    logic                    id_valid;
    logic [SLOTS*2*AW-1:0]   id_rs;
    logic [SLOTS*2-1:0]      id_rs_used;
    logic [SLOTS*AW-1:0]     id_rd;
    logic [SLOTS-1:0]        id_we;
    logic [SLOTS-1:0]        id_load;
    logic                    flush;
    logic [SLOTS*2*DW-1:0]   rf_data;
    logic [SLOTS*DW-1:0]     ex_res;
    logic [SLOTS*DW-1:0]     mem_res;
    logic [SLOTS*DW-1:0]     wb_res;
    logic [SLOTS*2*DW-1:0]   opnd;
    logic [SLOTS*4-1:0]      fwd_sel;
    logic                    stall;
    logic [CW-1:0]           stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_load, flush,
               rf_data, ex_res, mem_res, wb_res,
        input  opnd, fwd_sel, stall, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_load, flush,
               rf_data, ex_res, mem_res, wb_res,
        output opnd, fwd_sel, stall, stall_count
    );
endinterface

// File: rtl/vliw_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// vliw_fwd_hazard_unit
// Forwarding and load-use hazard unit for an N-slot VLIW pipeline
// (ID -> EX -> MEM -> WB). An internal scoreboard tracks the destination
// register of every slot in EX, MEM and WB; each ID source operand is taken
// from the youngest matching in-flight result or from the register file.
// A load in EX feeding an ID operand raises a one-cycle stall.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset
//   bus    - slave modport: ID bundle, flush, result buses in;
//            opnd, fwd_sel (00 rf, 01 EX, 10 MEM, 11 WB), stall,
//            stall_count out
// ----------------------------------------------------------------------------
module vliw_fwd_hazard_unit #(
    parameter int SLOTS = 2,
    parameter int AW    = 3,
    parameter int DW    = 32,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    vliw_fwd_hazard_unit_if.slave   bus
);
    localparam int OPS = SLOTS * 2;

    // Scoreboard stage records, one entry per slot.
    logic [SLOTS-1:0] ex_v,  ex_we,  ex_ld;
    logic [SLOTS-1:0] mem_v, mem_we;
    logic [SLOTS-1:0] wb_v,  wb_we;
    logic [AW-1:0]    ex_rd  [SLOTS];
    logic [AW-1:0]    mem_rd [SLOTS];
    logic [AW-1:0]    wb_rd  [SLOTS];

    logic [CW-1:0]        stall_cnt;
    logic [OPS*DW-1:0]    opnd_c;
    logic [OPS*2-1:0]     sel_c;
    logic                 load_use;
    logic [AW-1:0]        rs;
    logic                 take;

    // Operand selection. Stages are evaluated oldest first so that a younger
    // stage overrides an older one; within a stage slots are scanned in
    // ascending order so the highest matching slot wins. Any EX match, load
    // or not, overrides MEM/WB: for a load the select is meaningless because
    // the stall discards this cycle's operands anyway.
    always_comb begin
        opnd_c   = bus.rf_data;
        sel_c    = '0;
        load_use = 1'b0;
        rs       = '0;
        for (int j = 0; j < OPS; j++) begin
            rs = bus.id_rs[j*AW +: AW];
            for (int p = 0; p < SLOTS; p++) begin
                if (bus.id_rs_used[j] && wb_v[p] && wb_we[p] && wb_rd[p] == rs) begin
                    sel_c[j*2 +: 2]   = 2'b11;
                    opnd_c[j*DW +: DW] = bus.wb_res[p*DW +: DW];
                end
            end
            for (int p = 0; p < SLOTS; p++) begin
                if (bus.id_rs_used[j] && mem_v[p] && mem_we[p] && mem_rd[p] == rs) begin
                    sel_c[j*2 +: 2]   = 2'b10;
                    opnd_c[j*DW +: DW] = bus.mem_res[p*DW +: DW];
                end
            end
            for (int p = 0; p < SLOTS; p++) begin
                if (bus.id_rs_used[j] && ex_v[p] && ex_we[p] && ex_rd[p] == rs) begin
                    sel_c[j*2 +: 2]   = 2'b01;
                    opnd_c[j*DW +: DW] = bus.ex_res[p*DW +: DW];
                    if (ex_ld[p]) begin
                        load_use = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.opnd        = opnd_c;
    assign bus.fwd_sel     = sel_c;
    // Flush dominates: a killed bundle never waits on a load.
    assign bus.stall       = bus.id_valid & ~bus.flush & load_use;
    assign bus.stall_count = stall_cnt;

    assign take = bus.id_valid & ~bus.stall & ~bus.flush;

    // Valid bits and the counter carry reset; clearing every stage's valid
    // makes the scoreboard empty as soon as reset is seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_v      <= '0;
            mem_v     <= '0;
            wb_v      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_v  <= {SLOTS{take}};
            mem_v <= ex_v;
            wb_v  <= mem_v;
            if (bus.stall && stall_cnt != {CW{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Payload fields only matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
        ex_we  <= bus.id_we;
        ex_ld  <= bus.id_load;
        mem_we <= ex_we;
        wb_we  <= mem_we;
        for (int p = 0; p < SLOTS; p++) begin
            ex_rd[p]  <= bus.id_rd[p*AW +: AW];
            mem_rd[p] <= ex_rd[p];
            wb_rd[p]  <= mem_rd[p];
        end
    end
endmodule

// File: tb/tb_vliw_fwd_hazard_unit.sv
module tb_vliw_fwd_hazard_unit;
    localparam int SLOTS = 2;
    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int CW    = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vliw_fwd_hazard_unit_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .CW(CW)) bus ();

    vliw_fwd_hazard_unit #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_bundle();
        bus.id_valid   = 1'b0;
        bus.id_rs      = '0;
        bus.id_rs_used = '0;
        bus.id_rd      = '0;
        bus.id_we      = '0;
        bus.id_load    = '0;
        bus.flush      = 1'b0;
        bus.ex_res     = '0;
        bus.mem_res    = '0;
        bus.wb_res     = '0;
        for (int j = 0; j < SLOTS*2; j++) begin
            bus.rf_data[j*DW +: DW] = 32'hF000_0000 + j;
        end
    endtask

    task automatic set_rs(input int s, input int k, input int r);
        bus.id_rs[(2*s+k)*AW +: AW] = r[AW-1:0];
        bus.id_rs_used[2*s+k]       = 1'b1;
    endtask

    task automatic set_rd(input int s, input int r, input logic ld);
        bus.id_rd[s*AW +: AW] = r[AW-1:0];
        bus.id_we[s]          = 1'b1;
        bus.id_load[s]        = ld;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        clear_bundle();
        repeat (n) @(posedge clk);
    endtask

    function automatic logic [1:0] sel_of(input int j);
        return bus.fwd_sel[2*j +: 2];
    endfunction

    function automatic logic [DW-1:0] opnd_of(input int j);
        return bus.opnd[j*DW +: DW];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        clear_bundle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall_count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
        end
        checks++;
        if (bus.fwd_sel !== 4'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: sel %b stall %b expected 0/0", bus.fwd_sel, bus.stall);
        end
        reset = 1'b1;
    endtask

    task automatic test_empty();
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rs(0, 0, 3);
        bus.rf_data[0 +: DW] = 32'h11;
        #1;
        checks++;
        if (bus.fwd_sel !== 4'b0) begin
            errors++; $display("FAIL empty_sel: got %b expected 0", bus.fwd_sel);
        end
        checks++;
        if (opnd_of(0) !== 32'h11) begin
            errors++; $display("FAIL empty_opnd: got %h expected 11", opnd_of(0));
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL empty_stall: got %b expected 0", bus.stall);
        end
        idle(3);
    endtask

    task automatic test_ex_mem_wb();
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rd(1, 2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rs(0, 1, 2);
        bus.ex_res[1*DW +: DW]  = 32'hABCD;
        bus.mem_res[1*DW +: DW] = 32'h1234;
        bus.wb_res[1*DW +: DW]  = 32'h5678;
        #1;
        checks++;
        if (sel_of(1) !== 2'b01 || opnd_of(1) !== 32'hABCD) begin
            errors++; $display("FAIL ex_fwd: sel %b opnd %h expected 01 abcd", sel_of(1), opnd_of(1));
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL ex_fwd_stall: got %b expected 0", bus.stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel_of(1) !== 2'b10 || opnd_of(1) !== 32'h1234) begin
            errors++; $display("FAIL mem_fwd: sel %b opnd %h expected 10 1234", sel_of(1), opnd_of(1));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel_of(1) !== 2'b11 || opnd_of(1) !== 32'h5678) begin
            errors++; $display("FAIL wb_fwd: sel %b opnd %h expected 11 5678", sel_of(1), opnd_of(1));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel_of(1) !== 2'b00 || opnd_of(1) !== 32'hF000_0001) begin
            errors++; $display("FAIL retired_rf: sel %b opnd %h expected 00 f0000001", sel_of(1), opnd_of(1));
        end
        idle(3);
    endtask

    task automatic test_same_stage();
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rd(0, 5, 1'b0);
        set_rd(1, 5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rs(1, 0, 5);
        bus.ex_res  = {32'h2, 32'h1};
        bus.mem_res = {32'h20, 32'h10};
        #1;
        checks++;
        if (sel_of(2) !== 2'b01 || opnd_of(2) !== 32'h2) begin
            errors++; $display("FAIL same_ex: sel %b opnd %h expected 01 2", sel_of(2), opnd_of(2));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sel_of(2) !== 2'b10 || opnd_of(2) !== 32'h20) begin
            errors++; $display("FAIL same_mem: sel %b opnd %h expected 10 20", sel_of(2), opnd_of(2));
        end
        idle(3);
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rd(0, 4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rs(1, 1, 4);
        bus.mem_res[0 +: DW] = 32'h4444;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %b expected 1", bus.stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL load_use_release: got %b expected 0", bus.stall);
        end
        checks++;
        if (sel_of(3) !== 2'b10 || opnd_of(3) !== 32'h4444) begin
            errors++; $display("FAIL load_use_mem: sel %b opnd %h expected 10 4444", sel_of(3), opnd_of(3));
        end
        checks++;
        if (bus.stall_count !== 4'd1) begin
            errors++; $display("FAIL load_use_count: got %0d expected 1", bus.stall_count);
        end
        idle(3);
    endtask

    task automatic test_flush();
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rd(0, 4, 1'b1);
        @(posedge clk);
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        bus.flush    = 1'b1;
        set_rs(1, 1, 4);
        set_rd(1, 7, 1'b0);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b expected 0", bus.stall);
        end
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rs(0, 0, 7);
        set_rs(0, 1, 4);
        bus.id_rs[2*AW +: AW] = 3'd4;
        #1;
        checks++;
        if (bus.stall_count !== 4'd1) begin
            errors++; $display("FAIL flush_count: got %0d expected 1", bus.stall_count);
        end
        checks++;
        if (sel_of(0) !== 2'b00 || opnd_of(0) !== 32'hF000_0000) begin
            errors++; $display("FAIL flush_bubble: sel %b opnd %h expected 00 f0000000", sel_of(0), opnd_of(0));
        end
        checks++;
        if (sel_of(1) !== 2'b10) begin
            errors++; $display("FAIL flush_keeps_load: sel %b expected 10", sel_of(1));
        end
        checks++;
        if (sel_of(2) !== 2'b00) begin
            errors++; $display("FAIL unused_operand: sel %b expected 00", sel_of(2));
        end
        idle(3);
    endtask

    task automatic test_saturate();
        int  n;
        int  cyc;
        logic st;
        n   = 0;
        cyc = 0;
        @(negedge clk);
        clear_bundle();
        bus.id_valid = 1'b1;
        set_rd(0, 1, 1'b1);
        set_rs(1, 0, 1);
        while (n < 19 && cyc < 200) begin
            @(negedge clk);
            #1;
            st = bus.stall;
            if (st) n++;
            cyc++;
            @(posedge clk);
            #1;
            if (st && n == 5) begin
                checks++;
                if (bus.stall_count !== 4'd6) begin
                    errors++; $display("FAIL count_mid: got %0d expected 6", bus.stall_count);
                end
            end
        end
        checks++;
        if (n != 19) begin
            errors++; $display("FAIL stall_timeout: got %0d stalls expected 19", n);
        end
        checks++;
        if (bus.stall_count !== 4'd15) begin
            errors++; $display("FAIL count_saturate: got %0d expected 15", bus.stall_count);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall_count !== 4'd0) begin
            errors++; $display("FAIL mid_reset_count: got %0d expected 0", bus.stall_count);
        end
        checks++;
        if (bus.fwd_sel !== 4'b0 || opnd_of(2) !== 32'hF000_0002) begin
            errors++; $display("FAIL mid_reset_sel: sel %b opnd %h expected 0 f0000002", bus.fwd_sel, opnd_of(2));
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL mid_reset_stall: got %b expected 0", bus.stall);
        end
        reset = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_bundle();
        test_reset();
        test_empty();
        test_ex_mem_wb();
        test_same_stage();
        test_load_use();
        test_flush();
        test_saturate();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
